// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the counter sequencer slice.
package counter_seq_pkg;
  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/sync_counter_core.sv
// Synchronous up-counter register; load has priority over enable.
module sync_counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)     r_q <= '0;
    else if (load) r_q <= d;
    else if (en)   r_q <= r_q + 1'b1;
  end

  assign q = r_q;
endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer: owns the FSM and latched command, steers the counter core.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             cmd_auto,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);
  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [REP_W-1:0] r_reps_left;
  logic             r_auto;
  logic             r_err;

  logic             w_at_hi;
  logic             w_en;
  logic             w_load;
  logic             w_in_run;

  assign w_in_run = (r_state == ST_RUN);
  assign w_at_hi  = (q == r_hi);

  // Abort freezes q: neither load nor count in the aborting cycle.
  assign w_en   = w_in_run && !w_at_hi && !abort;
  assign w_load = ((r_state == ST_LOAD) && !abort) ||
                  (w_in_run && w_at_hi && !abort && (r_auto || (r_reps_left != '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_reps_left <= '0;
      r_auto      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_lo <= cmd_hi) begin
              r_lo        <= cmd_lo;
              r_hi        <= cmd_hi;
              r_reps_left <= cmd_reps;
              r_auto      <= cmd_auto;
              r_state     <= ST_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: r_state <= abort ? ST_IDLE : ST_RUN;
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_at_hi && !r_auto) begin
            if (r_reps_left != '0) r_reps_left <= r_reps_left - 1'b1;
            else                   r_state     <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sync_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .load  (w_load),
    .d     (r_lo),
    .q     (q)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_LOAD) || w_in_run;
  assign wrap      = w_in_run && w_at_hi;
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
endmodule
